mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of the data words on both request and response buses.
REQ-002 Parameter ADDR_WIDTH, default 16, width of the request address.
REQ-003 Parameter DEPTH_LOG2, default 8, log2 of the number of storage words (default 256 words).
REQ-004 Parameter WAIT_CYCLES, default 2, range 0..15, number of wait states inserted before each response.
REQ-005 One clock and one reset: the reset is asynchronous and active-high, with the ports named sys_clk and sys_reset as in the rest of the codebase.
REQ-006 sys_clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-007 sys_reset  input  1  asynchronous active-high reset.
REQ-008 mem_read_en  input  1  read request, held by the initiator until rsp_ready.
REQ-009 mem_write_en  input  1  write request, held by the initiator until rsp_ready.
REQ-010 mem_addr  input  ADDR_WIDTH  word address of the request.
REQ-011 mem_wdata  input  DATA_WIDTH  write data.
REQ-012 rsp_rdata  output  DATA_WIDTH  read data, valid while rsp_ready is high.
REQ-013 rsp_ready  output  1  one-cycle completion pulse for the accepted request.
REQ-014 busy  output  1  high from request acceptance through the response cycle.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-016 IDLE -> WAIT occurs when (mem_read_en | mem_write_en) is sampled high and WAIT_CYCLES > 0; IDLE -> RESP occurs under the same condition when WAIT_CYCLES = 0.
REQ-017 On acceptance, the block SHALL latch the address, write data and operation type; input changes during WAIT or RESP SHALL be ignored.
REQ-018 In WAIT, a down-counter loaded with WAIT_CYCLES-1 SHALL decrement each cycle; the FSM SHALL move to RESP when the counter is 0.
REQ-019 RESP SHALL last exactly one cycle with rsp_ready=1, then the FSM SHALL return unconditionally to IDLE.
REQ-020 Latency: a request sampled at edge N SHALL produce rsp_ready high in cycle N+1+WAIT_CYCLES.
REQ-021 Back-to-back requests: a request still high in the IDLE cycle after RESP SHALL be accepted as a new request, giving a minimum spacing of WAIT_CYCLES+2 cycles.
REQ-022 Write: the storage word is updated on the RESP edge, and rsp_rdata SHALL equal the written data during RESP.
REQ-023 Read: rsp_rdata SHALL equal the stored word at the latched address during RESP and SHALL hold that value until the next response.
REQ-024 Simultaneous read and write enables SHALL be treated as a write.
REQ-025 The storage index SHALL be mem_addr[DEPTH_LOG2-1:0]; upper address bits are handled per REQ-030/031.
REQ-026 busy SHALL be high in the WAIT and RESP states.

Reset
REQ-027 While sys_reset is high: FSM=IDLE, counter=0, rsp_ready=0, busy=0, rsp_rdata=0.
REQ-028 A reset during WAIT or RESP SHALL abort the request with no response pulse and no storage write; storage contents are not reset.

Configuration
REQ-029 The macro MEM_RESPONDER_ERR_EN selects out-of-range address checking.
REQ-030 With MEM_RESPONDER_ERR_EN defined: an output rsp_err (1 bit, reset 0) is added and is asserted with rsp_ready when any upper address bit is set; an errored write SHALL not modify storage, and an errored read SHALL return 0.
REQ-031 Without MEM_RESPONDER_ERR_EN: the rsp_err port is absent and addresses wrap modulo 2^DEPTH_LOG2.

Structure
REQ-032 Package mem_responder_pkg SHALL hold the state enum (IDLE/WAIT/RESP), default parameter constants and the counter width (4).
REQ-033 Storage SHALL be the sub-module mem_responder_array: a single-port synchronous-write, asynchronous-read, non-reset register array.

Verification
REQ-034 With WAIT_CYCLES=2: write 0xDEADBEEF to address 0x0010 -> rsp_ready in cycle N+3 for one cycle, busy high for cycles N+1 to N+3.
REQ-035 Read address 0x0010 after REQ-034 -> rsp_rdata=0xDEADBEEF with rsp_ready; rsp_rdata holds 0xDEADBEEF afterwards.
REQ-036 With WAIT_CYCLES=0: hold mem_read_en high continuously -> rsp_ready pulses every 2 cycles.
REQ-037 Assert read and write together with data 0x12345678 at address 0x0001 -> write performed, rsp_rdata=0x12345678; a subsequent read returns 0x12345678.
REQ-038 Assert sys_reset during WAIT of a write to 0x0020 -> no rsp_ready, busy=0 at once; a later read of 0x0020 returns its prior value.
REQ-039 ERR_EN build, write to 0x0100 -> rsp_err=1 with rsp_ready and word 0x00 unchanged; non-ERR build -> word 0x00 overwritten.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types and default constants for the wait-state memory responder.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_ADDR_WIDTH  = 16;
    localparam int DEF_DEPTH_LOG2  = 8;
    localparam int DEF_WAIT_CYCLES = 2;
    localparam int CNT_W           = 4;

endpackage

// File: rtl/mem_responder_array.sv
// Word storage for mem_responder: synchronous write, combinational read, no reset.
module mem_responder_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  sys_clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset so contents survive sys_reset and map onto plain RAM/flops without reset fan-out.
    always_ff @(posedge sys_clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_responder.sv
// Single-port memory responder with programmable wait states.
// Define MEM_RESPONDER_ERR_EN to add out-of-range address checking and the rsp_err output.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DEPTH_LOG2  = DEF_DEPTH_LOG2,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic                  sys_clk,
    input  logic                  sys_reset,
    input  logic                  mem_read_en,
    input  logic                  mem_write_en,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_ready,
    output logic                  busy
`ifdef MEM_RESPONDER_ERR_EN
    ,
    output logic                  rsp_err
`endif
);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  is_write_q, is_write_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] arr_rdata;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  arr_we;

`ifdef MEM_RESPONDER_ERR_EN
    logic err_q, err_d;
    logic addr_err;

    assign addr_err = |mem_addr[ADDR_WIDTH-1:DEPTH_LOG2];
    assign arr_we   = (state_q == RESP) && is_write_q && !err_q;
    assign rsp_err  = (state_q == RESP) && err_q;
`else
    // Upper address bits are deliberately ignored: addresses wrap.
    logic addr_hi_unused;

    assign addr_hi_unused = |mem_addr[ADDR_WIDTH-1:DEPTH_LOG2];
    assign arr_we         = (state_q == RESP) && is_write_q;
`endif

    mem_responder_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .sys_clk(sys_clk),
        .we     (arr_we),
        .addr   (addr_q),
        .wdata  (wdata_q),
        .rdata  (arr_rdata)
    );

    always_comb begin
        resp_data = is_write_q ? wdata_q : arr_rdata;
`ifdef MEM_RESPONDER_ERR_EN
        if (err_q && !is_write_q) begin
            resp_data = '0;
        end
`endif
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        rdata_d    = rdata_q;
`ifdef MEM_RESPONDER_ERR_EN
        err_d      = err_q;
`endif
        rsp_ready  = 1'b0;
        busy       = 1'b0;
        rsp_rdata  = rdata_q;

        case (state_q)
            IDLE: begin
                if (mem_read_en || mem_write_en) begin
                    addr_d     = mem_addr[DEPTH_LOG2-1:0];
                    wdata_d    = mem_wdata;
                    is_write_d = mem_write_en;
`ifdef MEM_RESPONDER_ERR_EN
                    err_d      = addr_err;
`endif
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                busy      = 1'b1;
                rsp_ready = 1'b1;
                rsp_rdata = resp_data;
                rdata_d   = resp_data;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            rdata_q    <= '0;
`ifdef MEM_RESPONDER_ERR_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
            rdata_q    <= rdata_d;
`ifdef MEM_RESPONDER_ERR_EN
            err_q      <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed, table-driven bench for mem_responder (WAIT_CYCLES=2 and WAIT_CYCLES=0 instances).
module tb_mem_responder;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int DL = 8;
    localparam int WC = 2;

`ifdef MEM_RESPONDER_ERR_EN
    localparam logic [31:0] WORD0_AFTER_HI = 32'h11111111;
    localparam logic [31:0] READ_HI        = 32'h00000000;
`else
    localparam logic [31:0] WORD0_AFTER_HI = 32'h22222222;
    localparam logic [31:0] READ_HI        = 32'h22222222;
`endif

    logic          sys_clk = 1'b0;
    logic          sys_reset = 1'b1;
    logic          mem_read_en, mem_write_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_ready, busy;

    logic          z_read_en, z_write_en;
    logic [AW-1:0] z_addr;
    logic [DW-1:0] z_wdata;
    logic [DW-1:0] z_rdata;
    logic          z_ready, z_busy;
`ifdef MEM_RESPONDER_ERR_EN
    logic          rsp_err, z_err;
`endif

    always #5 sys_clk = ~sys_clk;

    mem_responder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_LOG2(DL), .WAIT_CYCLES(WC)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_reset   (sys_reset),
        .mem_read_en (mem_read_en),
        .mem_write_en(mem_write_en),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .rsp_rdata   (rsp_rdata),
        .rsp_ready   (rsp_ready),
        .busy        (busy)
`ifdef MEM_RESPONDER_ERR_EN
        ,
        .rsp_err     (rsp_err)
`endif
    );

    mem_responder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_LOG2(DL), .WAIT_CYCLES(0)
    ) dut0 (
        .sys_clk     (sys_clk),
        .sys_reset   (sys_reset),
        .mem_read_en (z_read_en),
        .mem_write_en(z_write_en),
        .mem_addr    (z_addr),
        .mem_wdata   (z_wdata),
        .rsp_rdata   (z_rdata),
        .rsp_ready   (z_ready),
        .busy        (z_busy)
`ifdef MEM_RESPONDER_ERR_EN
        ,
        .rsp_err     (z_err)
`endif
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] last_rsp = '0;
    vec_t        vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_req(input vec_t v, input int idx);
        int k;
        mem_read_en  = v.rd;
        mem_write_en = v.wr;
        mem_addr     = v.addr;
        mem_wdata    = v.wdata;
        for (k = 1; k <= 20; k++) begin
            @(negedge sys_clk);
            check($sformatf("v%0d busy c%0d", idx, k), {31'b0, busy}, 32'd1);
            if (k == 1) begin
                check($sformatf("v%0d prev_hold", idx), rsp_rdata, last_rsp);
                mem_addr  = ~v.addr;
                mem_wdata = ~v.wdata;
            end
            if (rsp_ready) break;
        end
        check($sformatf("v%0d latency", idx), k, WC + 1);
        check($sformatf("v%0d rdata", idx), rsp_rdata, v.exp_rdata);
`ifdef MEM_RESPONDER_ERR_EN
        check($sformatf("v%0d err", idx), {31'b0, rsp_err}, {31'b0, v.exp_err});
`endif
        last_rsp     = v.exp_rdata;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        @(negedge sys_clk);
        check($sformatf("v%0d ready_drop", idx), {31'b0, rsp_ready}, 32'd0);
        check($sformatf("v%0d busy_drop", idx), {31'b0, busy}, 32'd0);
        check($sformatf("v%0d rdata_hold", idx), rsp_rdata, last_rsp);
    endtask

    initial begin
        int first;
        int second;

        vecs[0] = '{1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 16'h0010, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 16'h0001, 32'h12345678, 32'h12345678, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 16'h0001, 32'h0,        32'h12345678, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 16'h0020, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 16'h0000, 32'h11111111, 32'h11111111, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 16'h0100, 32'h22222222, 32'h22222222, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 16'h0000, 32'h0,        WORD0_AFTER_HI, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 16'h0100, 32'h0,        READ_HI,        1'b1};
        vecs[9] = '{1'b1, 1'b0, 16'h0010, 32'h0,        32'hDEADBEEF, 1'b0};

        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        z_read_en    = 1'b0;
        z_write_en   = 1'b0;
        z_addr       = '0;
        z_wdata      = '0;

        @(negedge sys_clk);
        check("reset ready", {31'b0, rsp_ready}, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset rdata", rsp_rdata, 32'd0);
        sys_reset = 1'b0;
        @(negedge sys_clk);

        for (int i = 0; i < 10; i++) begin
            run_req(vecs[i], i);
        end

        // Read held high: responses land at cycles 3 and 7 (spacing WAIT_CYCLES+2).
        first  = 0;
        second = 0;
        mem_read_en = 1'b1;
        mem_addr    = 16'h0010;
        for (int k = 1; k <= 20 && second == 0; k++) begin
            @(negedge sys_clk);
            if (rsp_ready) begin
                if (first == 0) first = k;
                else second = k;
            end
        end
        check("b2b first", first, 32'd3);
        check("b2b second", second, 32'd7);
        check("b2b rdata", rsp_rdata, 32'hDEADBEEF);
        mem_read_en = 1'b0;
        last_rsp    = 32'hDEADBEEF;
        @(negedge sys_clk);

        // Reset in the middle of a write's wait states aborts it.
        mem_write_en = 1'b1;
        mem_addr     = 16'h0020;
        mem_wdata    = 32'hBAD0BAD0;
        @(negedge sys_clk);
        check("abort busy_wait", {31'b0, busy}, 32'd1);
        sys_reset = 1'b1;
        #1;
        check("abort busy", {31'b0, busy}, 32'd0);
        check("abort ready", {31'b0, rsp_ready}, 32'd0);
        check("abort rdata", rsp_rdata, 32'd0);
        mem_write_en = 1'b0;
        @(negedge sys_clk);
        sys_reset = 1'b0;
        last_rsp  = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge sys_clk);
            check($sformatf("abort no_ready c%0d", k), {31'b0, rsp_ready}, 32'd0);
        end
        run_req('{1'b1, 1'b0, 16'h0020, 32'h0, 32'hA5A5A5A5, 1'b0}, 10);

        // Zero wait states, read held: ready pulses every other cycle.
        z_read_en = 1'b1;
        z_addr    = 16'h0003;
        for (int k = 1; k <= 8; k++) begin
            @(negedge sys_clk);
            check($sformatf("w0 ready c%0d", k), {31'b0, z_ready}, k % 2);
            check($sformatf("w0 busy c%0d", k), {31'b0, z_busy}, k % 2);
        end
        z_read_en = 1'b0;
        @(negedge sys_clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
